// File: rtl/transpose_stream_pp_if.sv
// Valid/ready stream carrying one matrix row or column per beat.
// The single side-band bit is the tile's column order on the input port and the
// last-column marker on the output port.
interface transpose_stream_pp_if #(
    parameter int WIDTH = 64
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             side;

    modport master (output valid, output data, output side, input  ready);
    modport slave  (input  valid, input  data, input  side, output ready);
endinterface

// File: rtl/transpose_stream_pp.sv
// Streaming NxN transpose with two ping-pong register banks: one tile loads by
// rows while the other drains by columns, in ascending or descending order.
module transpose_stream_pp #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    transpose_stream_pp_if.slave         in_s,
    transpose_stream_pp_if.master        out_m,
    output logic                         busy
);
    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef logic [DATA_WIDTH-1:0] elem_t;

    elem_t                   bank [2][N][N];
    logic [1:0]              bank_full;
    logic [1:0]              bank_full_nxt;
    logic [1:0]              dir;
    logic                    wr_sel;
    logic                    rd_sel;
    logic [CW-1:0]           wr_cnt;
    logic [CW-1:0]           rd_cnt;
    logic [CW-1:0]           col_idx;
    logic                    in_fire;
    logic                    out_fire;
    logic                    wr_last;
    logic                    rd_last;
    logic [N*DATA_WIDTH-1:0] col_data;

    // in_ready must read 0 while reset is held, so rst_n gates it directly.
    assign in_s.ready = rst_n && !bank_full[wr_sel] && !clear;
    assign in_fire    = in_s.valid && in_s.ready;
    assign wr_last    = (wr_cnt == LAST_IDX);

    assign out_m.valid = bank_full[rd_sel];
    assign out_fire    = out_m.valid && out_m.ready;
    assign rd_last     = (rd_cnt == LAST_IDX);
    assign out_m.side  = out_m.valid && rd_last;
    assign out_m.data  = col_data;

    assign busy = (|bank_full) || (wr_cnt != '0);

    assign col_idx = dir[rd_sel] ? (LAST_IDX - rd_cnt) : rd_cnt;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        col_data = '0;
        for (int r = 0; r < N; r++) begin
            col_data[r*DATA_WIDTH +: DATA_WIDTH] = bank[rd_sel][r][col_idx];
        end
    end

    // The two banks are always distinct whenever both a fill and a drain complete
    // in one cycle, so the set and clear never collide.
    always_comb begin
        bank_full_nxt = bank_full;
        if (out_fire && rd_last) bank_full_nxt[rd_sel] = 1'b0;
        if (in_fire && wr_last)  bank_full_nxt[wr_sel] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
            dir       <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else if (clear) begin
            bank_full <= '0;
            dir       <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else begin
            bank_full <= bank_full_nxt;
            if (in_fire) begin
                if (wr_cnt == '0) dir[wr_sel] <= in_s.side;
                if (wr_last) begin
                    wr_sel <= ~wr_sel;
                    wr_cnt <= '0;
                end else begin
                    wr_cnt <= wr_cnt + CW'(1);
                end
            end
            if (out_fire) begin
                if (rd_last) begin
                    rd_sel <= ~rd_sel;
                    rd_cnt <= '0;
                end else begin
                    rd_cnt <= rd_cnt + CW'(1);
                end
            end
        end
    end

    // NOTE: the bank storage is reset and flushed so out_col reads zero after reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        bank[b][r][c] <= '0;
        end else if (clear) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        bank[b][r][c] <= '0;
        end else if (in_fire) begin
            for (int c = 0; c < N; c++)
                bank[wr_sel][wr_cnt][c] <= in_s.data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: tb/tb_transpose_stream_pp.sv
// Self-checking bench for transpose_stream_pp: tiles are modelled as they are
// driven, expected columns queued, and compared as the DUT emits them.
module tb_transpose_stream_pp;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int W  = N * DW;

    typedef struct packed {
        logic         last;
        logic [W-1:0] col;
    } beat_t;

    logic clk;
    logic rst_n;
    logic clear;
    logic busy;

    transpose_stream_pp_if #(.WIDTH(W)) in_if ();
    transpose_stream_pp_if #(.WIDTH(W)) out_if ();

    transpose_stream_pp #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .in_s  (in_if.slave),
        .out_m (out_if.master),
        .busy  (busy)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           acc_count;
    int           stall_cnt;
    int           rise;
    bit           drv_done;
    bit           rnd_en   = 0;
    logic         or_lvl   = 0;
    beat_t        sb[$];
    logic [W-1:0] obs[$];
    int           hs_cycles[$];
    int           acc_cycles[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Single owner of out_ready; updates at +2 after each edge.
    initial begin
        out_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_if.ready = rnd_en ? 1'($urandom_range(0, 1)) : or_lvl;
        end
    end

    // Output monitor: scoreboard compare and stall stability.
    initial begin
        beat_t        e;
        bit           prev_stall = 0;
        logic [W-1:0] prev_col   = '0;
        logic         prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || clear) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", out_if.valid, 1);
                    check("stall_col", out_if.data, prev_col);
                    check("stall_last", out_if.side, prev_last);
                end
                if (!out_if.valid) check("last_idle", out_if.side, 0);
                if (out_if.valid && out_if.ready) begin
                    hs_cycles.push_back(cyc + 1);
                    obs.push_back(out_if.data);
                    check("sb_has_entry", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("out_col", out_if.data, e.col);
                        check("out_last", out_if.side, e.last);
                    end
                    prev_stall = 0;
                end else if (out_if.valid) begin
                    prev_stall = 1;
                    prev_col   = out_if.data;
                    prev_last  = out_if.side;
                end else begin
                    prev_stall = 0;
                end
            end
        end
    end

    // Entered and left at +1 after a rising edge.
    task automatic send_row(input logic [W-1:0] row, input logic d);
        int waited = 0;
        in_if.valid = 1'b1;
        in_if.data  = row;
        in_if.side  = d;
        forever begin
            @(negedge clk);
            if (in_if.ready) begin
                acc_cycles.push_back(cyc + 1);
                acc_count++;
                @(posedge clk);
                #1;
                break;
            end
            stall_cnt++;
            @(posedge clk);
            #1;
            waited++;
            if (waited > 500) begin
                check("in_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic send_tile(input logic [7:0] tag, input logic d, input bit toggle, input int nrows);
        logic [W-1:0] rows [N];
        logic [W-1:0] col;
        int           kk;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                rows[r][c*DW +: DW] = {tag, r[3:0], c[3:0]};
        for (int r = 0; r < nrows; r++)
            send_row(rows[r], (toggle && r > 0) ? ~d : d);
        in_if.valid = 1'b0;
        if (nrows == N) begin
            for (int k = 0; k < N; k++) begin
                kk = d ? (N - 1 - k) : k;
                for (int r = 0; r < N; r++) col[r*DW +: DW] = rows[r][kk*DW +: DW];
                sb.push_back('{last: (k == N - 1), col: col});
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_if.valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.side  = 1'b0;
        acc_count   = 0;
        stall_cnt   = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_if.ready, 0);
        check("rst_out_valid", out_if.valid, 0);
        check("rst_out_last", out_if.side, 0);
        check("rst_out_col", out_if.data, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_if.ready, 1);
        @(posedge clk);
        #1;

        // Basic ascending tile, M[r][c] = 16'h00rc.
        or_lvl = 1;
        obs.delete(); hs_cycles.delete(); acc_cycles.delete();
        send_tile(8'h00, 1'b0, 0, N);
        @(negedge clk);
        check("lat_valid", out_if.valid, 1);
        wait_drain();
        check("basic_beats", obs.size(), 4);
        check("basic_latency", (hs_cycles.size() > 0 && acc_cycles.size() > 0) ? hs_cycles[0] - acc_cycles[0] : -1, 4);
        check("basic_col0", obs.size() > 0 ? obs[0] : '0, 64'h0030_0020_0010_0000);
        check("basic_col3", obs.size() > 3 ? obs[3] : '0, 64'h0033_0023_0013_0003);

        // Descending tile, in_dir flipped after the first beat.
        obs.delete();
        send_tile(8'h00, 1'b1, 1, N);
        wait_drain();
        check("desc_col0", obs.size() > 0 ? obs[0] : '0, 64'h0033_0023_0013_0003);
        check("desc_col3", obs.size() > 3 ? obs[3] : '0, 64'h0030_0020_0010_0000);

        // Eight back-to-back tiles with the sink always ready.
        stall_cnt = 0;
        hs_cycles.delete(); acc_cycles.delete();
        for (int t = 0; t < 8; t++) send_tile(8'(t + 1), t[0], 0, N);
        wait_drain();
        check("stream_no_in_stall", stall_cnt, 0);
        check("stream_beats", hs_cycles.size(), 32);
        check("stream_contiguous", hs_cycles.size() == 32 ? hs_cycles[31] - hs_cycles[0] : -1, 31);
        check("stream_latency", (hs_cycles.size() > 0 && acc_cycles.size() > 0) ? hs_cycles[0] - acc_cycles[0] : -1, 4);

        // Backpressure: three tiles into a blocked sink.
        or_lvl    = 0;
        acc_count = 0;
        drv_done  = 0;
        #2;
        fork
            begin
                for (int t = 0; t < 3; t++) send_tile(8'(8'hA0 + t), 1'b0, 0, N);
                drv_done = 1;
            end
        join_none
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("bp_accepted", acc_count, 8);
        check("bp_in_ready", in_if.ready, 0);
        @(posedge clk);
        #1;
        hs_cycles.delete();
        or_lvl = 1;
        rise   = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_if.ready) begin
                rise = cyc;
                break;
            end
        end
        check("bp_ready_return", rise, hs_cycles.size() > 3 ? hs_cycles[3] : -2);
        for (int i = 0; i < 500 && !drv_done; i++) @(posedge clk);
        check("bp_driver_done", drv_done, 1);
        #1;
        wait_drain();
        check("bp_total_accepted", acc_count, 12);

        // Random sink backpressure.
        rnd_en = 1;
        for (int t = 0; t < 4; t++) send_tile(8'(8'hB0 + t), t[0], 0, N);
        wait_drain();
        rnd_en = 0;
        or_lvl = 1;

        // Clear while tile 1 is half drained and tile 2 half written.
        or_lvl = 0;
        #2;
        send_tile(8'hC0, 1'b0, 0, N);
        send_tile(8'hC1, 1'b0, 0, 2);
        or_lvl = 1;
        repeat (2) @(posedge clk);
        #1;
        or_lvl      = 0;
        clear       = 1'b1;
        in_if.valid = 1'b1;
        in_if.data  = {W{1'b1}};
        @(negedge clk);
        check("clear_in_ready", in_if.ready, 0);
        @(posedge clk);
        #1;
        clear       = 1'b0;
        in_if.valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("clear_out_valid", out_if.valid, 0);
        check("clear_busy", busy, 0);
        check("clear_in_ready_after", in_if.ready, 1);
        check("clear_out_col", out_if.data, 0);
        @(posedge clk);
        #1;
        or_lvl = 1;
        send_tile(8'hC2, 1'b1, 0, N);
        wait_drain();

        // Asynchronous reset mid-beat with the same setup.
        or_lvl = 0;
        #2;
        send_tile(8'hD0, 1'b0, 0, N);
        send_tile(8'hD1, 1'b0, 0, 1);
        or_lvl = 1;
        repeat (2) @(posedge clk);
        #1;
        or_lvl      = 0;
        in_if.valid = 1'b1;
        in_if.data  = {W{1'b1}};
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_if.ready, 0);
        check("arst_out_valid", out_if.valid, 0);
        check("arst_out_col", out_if.data, 0);
        check("arst_busy", busy, 0);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_ready", in_if.ready, 1);
        check("arst_release_busy", busy, 0);
        @(posedge clk);
        #1;
        or_lvl = 1;
        send_tile(8'hD2, 1'b0, 0, N);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
